// File: rtl/edid_block_checker.sv
// EDID block checker.
// Collects one EDID block from the DDC read master's byte stream into local
// storage. It then checks the fixed 8-byte header and the mod-256 checksum,
// and extracts the manufacturer ID and the extension count. A registered read
// port exposes the stored block.
module edid_block_checker #(
    parameter int BLOCK_BYTES = 128,
    parameter int IDX_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_byte,
    output logic [IDX_W:0]   byte_count,
    output logic             done,
    output logic             header_ok,
    output logic             checksum_ok,
    output logic             short_err,
    output logic             overrun,
    output logic [15:0]      mfg_id,
    output logic [7:0]       ext_count
);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(BLOCK_BYTES);
    localparam logic [IDX_W:0]   HDR_LEN    = (IDX_W+1)'(8);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0] MFG_HI_IDX = IDX_W'(8);
    localparam logic [IDX_W-1:0] MFG_LO_IDX = IDX_W'(9);
    localparam logic [IDX_W-1:0] EXT_IDX    = IDX_W'(126);

    state_t           state_q, state_d;
    logic [IDX_W:0]   byte_count_q, byte_count_d;
    logic [7:0]       sum_q, sum_d;
    logic             hdr_match_q, hdr_match_d;
    logic             done_q, done_d;
    logic             header_ok_q, header_ok_d;
    logic             checksum_ok_q, checksum_ok_d;
    logic             short_err_q, short_err_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      mfg_id_q, mfg_id_d;
    logic [7:0]       ext_count_q, ext_count_d;
    logic [7:0]       rd_byte_q, rd_byte_d;

    logic [7:0]       mem [BLOCK_BYTES];
    logic [IDX_W-1:0] wr_idx;
    logic             mem_we;
    logic [7:0]       hdr_expect;

    // Write index is simply the count of bytes accepted so far.
    assign wr_idx = byte_count_q[IDX_W-1:0];
    assign mem_we = (state_q == ST_COLLECT) && in_valid && !clear;

    // Fixed EDID header pattern: 00 FF FF FF FF FF FF 00.
    always_comb begin
        if (wr_idx == IDX_W'(0) || wr_idx == IDX_W'(7)) begin
            hdr_expect = 8'h00;
        end else begin
            hdr_expect = 8'hFF;
        end
    end

    // Next-state logic: collection, header/checksum evaluation and clear handling.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d       = state_q;
        byte_count_d  = byte_count_q;
        sum_d         = sum_q;
        hdr_match_d   = hdr_match_q;
        done_d        = done_q;
        header_ok_d   = header_ok_q;
        checksum_ok_d = checksum_ok_q;
        short_err_d   = short_err_q;
        overrun_d     = overrun_q;
        mfg_id_d      = mfg_id_q;
        ext_count_d   = ext_count_q;
        rd_byte_d     = mem[rd_idx];

        if (clear) begin
            // clear beats a coincident strobe; mfg_id/ext_count are kept.
            state_d       = ST_COLLECT;
            byte_count_d  = '0;
            sum_d         = '0;
            hdr_match_d   = 1'b1;
            done_d        = 1'b0;
            header_ok_d   = 1'b0;
            checksum_ok_d = 1'b0;
            short_err_d   = 1'b0;
            overrun_d     = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        sum_d = sum_q + in_byte;
                        if (byte_count_q != FULL_COUNT) begin
                            byte_count_d = byte_count_q + 1'b1;
                        end
                        if (byte_count_q < HDR_LEN && in_byte != hdr_expect) begin
                            hdr_match_d = 1'b0;
                        end
                        if (wr_idx == MFG_HI_IDX) mfg_id_d[15:8] = in_byte;
                        if (wr_idx == MFG_LO_IDX) mfg_id_d[7:0]  = in_byte;
                        if (wr_idx == EXT_IDX)    ext_count_d    = in_byte;
                        if (wr_idx == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end else if (in_last) begin
                            short_err_d = 1'b1;
                            state_d     = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    header_ok_d   = hdr_match_q && (byte_count_q >= HDR_LEN);
                    checksum_ok_d = (sum_q == 8'h00) && !short_err_q;
                    done_d        = 1'b1;
                    state_d       = ST_DONE;
                    if (in_valid) overrun_d = 1'b1;
                end
                ST_DONE: begin
                    if (in_valid) overrun_d = 1'b1;
                end
                default: begin
                    state_d = ST_COLLECT;
                end
            endcase
        end
    end

    // State and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q       <= ST_COLLECT;
            byte_count_q  <= '0;
            sum_q         <= '0;
            hdr_match_q   <= 1'b1;
            done_q        <= 1'b0;
            header_ok_q   <= 1'b0;
            checksum_ok_q <= 1'b0;
            short_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            mfg_id_q      <= '0;
            ext_count_q   <= '0;
            rd_byte_q     <= '0;
        end else begin
            state_q       <= state_d;
            byte_count_q  <= byte_count_d;
            sum_q         <= sum_d;
            hdr_match_q   <= hdr_match_d;
            done_q        <= done_d;
            header_ok_q   <= header_ok_d;
            checksum_ok_q <= checksum_ok_d;
            short_err_q   <= short_err_d;
            overrun_q     <= overrun_d;
            mfg_id_q      <= mfg_id_d;
            ext_count_q   <= ext_count_d;
            rd_byte_q     <= rd_byte_d;
        end
    end

    // Block storage: written only while collecting.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Unwritten entries read back
        // stale data. Leaving it unreset lets it map onto plain RAM.
        if (mem_we) begin
            mem[wr_idx] <= in_byte;
        end
    end

    assign rd_byte     = rd_byte_q;
    assign byte_count  = byte_count_q;
    assign done        = done_q;
    assign header_ok   = header_ok_q;
    assign checksum_ok = checksum_ok_q;
    assign short_err   = short_err_q;
    assign overrun     = overrun_q;
    assign mfg_id      = mfg_id_q;
    assign ext_count   = ext_count_q;

endmodule

// File: tb/tb_edid_block_checker.sv
// Testbench for edid_block_checker.
// The driver pushes the expected block result and the expected readback bytes
// into queues. A monitor pops and compares them when done rises or when a
// readback completes.
module tb_edid_block_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_last;
    logic [6:0] rd_idx;
    logic [7:0] rd_byte;
    logic [7:0] byte_count;
    logic       done, header_ok, checksum_ok, short_err, overrun;
    logic [15:0] mfg_id;
    logic [7:0]  ext_count;

    typedef struct {
        logic        hdr;
        logic        cks;
        logic        sht;
        logic [15:0] mfg;
        logic [7:0]  ext;
        logic [7:0]  cnt;
    } res_t;

    res_t       res_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] blk [128];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       rd_req = 1'b0;
    logic       rd_req_cap = 1'b0;
    int         edge_cnt = 99;

    edid_block_checker dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .rd_idx(rd_idx),
        .rd_byte(rd_byte), .byte_count(byte_count), .done(done),
        .header_ok(header_ok), .checksum_ok(checksum_ok),
        .short_err(short_err), .overrun(overrun), .mfg_id(mfg_id),
        .ext_count(ext_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Track edges since the final strobe, and which cycles carried a read request.
    always @(posedge clk) begin
        rd_req_cap <= rd_req;
        if (in_valid && in_last && !clear) edge_cnt <= 1;
        else if (edge_cnt < 99) edge_cnt <= edge_cnt + 1;
    end

    // Monitor: compares block results on the rising edge of done, and readback bytes.
    initial begin
        logic done_prev;
        res_t r;
        logic [7:0] e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && done && !done_prev) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    check("latency", edge_cnt, 32'd2);
                    check("header_ok", header_ok, r.hdr);
                    check("checksum_ok", checksum_ok, r.cks);
                    check("short_err", short_err, r.sht);
                    check("mfg_id", mfg_id, r.mfg);
                    check("ext_count", ext_count, r.ext);
                    check("byte_count", byte_count, r.cnt);
                end
            end
            done_prev = done;
            if (rd_req_cap) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rd", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_byte", rd_byte, e);
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send blk[0..n-1], with in_last on the final byte when requested.
    task automatic send_blk(input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            send_byte(blk[i], last_on_end && (i == n - 1));
        end
    endtask

    task automatic build_valid();
        for (int i = 0; i < 128; i++) blk[i] = 8'h00;
        for (int i = 1; i < 7; i++) blk[i] = 8'hFF;
        blk[8]   = 8'h10;
        blk[9]   = 8'hAC;
        blk[126] = 8'h01;
        blk[127] = 8'h49;
    endtask

    task automatic expect_res(input logic hdr, input logic cks, input logic sht,
                              input logic [15:0] mfg, input logic [7:0] ext,
                              input logic [7:0] cnt);
        res_t r;
        r.hdr = hdr; r.cks = cks; r.sht = sht; r.mfg = mfg; r.ext = ext; r.cnt = cnt;
        res_q.push_back(r);
    endtask

    task automatic readback(input logic [6:0] idx, input logic [7:0] exp);
        rd_q.push_back(exp);
        rd_idx = idx;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    // Bounded wait for the monitor to drain both queues.
    task automatic wait_drained(input string name);
        int budget;
        budget = 20;
        while ((res_q.size() != 0 || rd_q.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check(name, res_q.size() + rd_q.size(), 32'd0);
        res_q.delete();
        rd_q.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("done_after_clear", done, 1'b0);
        check("count_after_clear", byte_count, 8'd0);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        in_last = 1'b0; rd_idx = 7'd0;
        #12;
        // Reset state
        check("rst_done", done, 1'b0);
        check("rst_count", byte_count, 8'd0);
        check("rst_flags", {header_ok, checksum_ok, short_err, overrun}, 4'b0000);
        check("rst_mfg", mfg_id, 16'h0000);
        check("rst_ext", ext_count, 8'h00);
        check("rst_rd_byte", rd_byte, 8'h00);
        tick();
        rst = 1'b1;
        tick();

        // 1: valid EDID
        build_valid();
        expect_res(1'b1, 1'b1, 1'b0, 16'h10AC, 8'h01, 8'd128);
        send_blk(128, 1'b1);
        wait_drained("t1_drain");
        readback(7'd9, 8'hAC);
        readback(7'd126, 8'h01);
        readback(7'd1, 8'hFF);
        wait_drained("t1_rd_drain");
        pulse_clear();

        // 2: bad checksum
        blk[127] = 8'h48;
        expect_res(1'b1, 1'b0, 1'b0, 16'h10AC, 8'h01, 8'd128);
        send_blk(128, 1'b1);
        wait_drained("t2_drain");
        pulse_clear();

        // 3: bad header, checksum still zero
        build_valid();
        blk[3]   = 8'hFE;
        blk[127] = 8'h4A;
        expect_res(1'b0, 1'b1, 1'b0, 16'h10AC, 8'h01, 8'd128);
        send_blk(128, 1'b1);
        wait_drained("t3_drain");
        readback(7'd3, 8'hFE);
        wait_drained("t3_rd_drain");
        pulse_clear();

        // 4: short read of 20 bytes, then a strobe while done
        build_valid();
        expect_res(1'b1, 1'b0, 1'b1, 16'h10AC, 8'h01, 8'd20);
        send_blk(20, 1'b1);
        wait_drained("t4_drain");
        check("t4_overrun_before", overrun, 1'b0);
        send_byte(8'h77, 1'b0);
        check("t4_overrun", overrun, 1'b1);
        check("t4_count_held", byte_count, 8'd20);
        check("t4_done_held", done, 1'b1);
        readback(7'd20, 8'h00);
        wait_drained("t4_rd_drain");
        pulse_clear();
        check("t4_overrun_cleared", overrun, 1'b0);

        // 5: clear mid-block coinciding with a strobe, then a valid block
        for (int i = 0; i < 50; i++) send_byte(8'h5A, 1'b0);
        check("t5_partial_count", byte_count, 8'd50);
        clear = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hFF;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("t5_dropped", byte_count, 8'd0);
        build_valid();
        expect_res(1'b1, 1'b1, 1'b0, 16'h10AC, 8'h01, 8'd128);
        send_blk(128, 1'b1);
        wait_drained("t5_drain");
        readback(7'd0, 8'h00);
        wait_drained("t5_rd_drain");
        pulse_clear();

        // 6: asynchronous reset mid-block, then a valid block
        send_blk(64, 1'b0);
        check("t6_partial_count", byte_count, 8'd64);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_count", byte_count, 8'd0);
        check("t6_async_done", done, 1'b0);
        check("t6_async_mfg", mfg_id, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        expect_res(1'b1, 1'b1, 1'b0, 16'h10AC, 8'h01, 8'd128);
        send_blk(128, 1'b1);
        wait_drained("t6_drain");
        readback(7'd9, 8'hAC);
        wait_drained("t6_rd_drain");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
